// File: rtl/sseg_scan_decoder.sv
// Recovers hex digits from a multiplexed, active-low 7-segment scan.
// Captures each digit after it settles and publishes complete frames.
module sseg_scan_decoder #(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] sseg,
  input  logic       dp,
  input  logic       clr_err,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dp_out,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       an_err,
  output logic       stale
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [7:0] S_LAST = 8'(SETTLE - 1);

  state_t r_state;
  state_t w_next;

  logic [11:0] w_in;
  logic [11:0] r_smp;
  logic [7:0]  r_cnt;
  logic [3:0]  r_mask;
  logic        r_bad;
  logic [3:0][3:0] r_sh;
  logic [3:0]  r_dsh;
  logic [3:0][3:0] r_dig;
  logic [3:0]  r_dpo;
  logic        r_fv;
  logic        r_serr;
  logic        r_aerr;
  logic [TW-1:0] r_to;

  logic [3:0] w_s_an;
  logic [6:0] w_s_seg;
  logic       w_s_dp;
  logic       w_chg;
  logic       w_an_chg;
  logic       w_oh_s;
  logic       w_oh_live;
  logic       w_idle_s;
  logic [1:0] w_idx;
  logic [4:0] w_dec;
  logic       w_ok;
  logic       w_cap;
  logic       w_aset;
  logic       w_full;
  logic       w_pub;
  logic [3:0] w_mask_nx;
  logic       w_bad_nx;

  function automatic logic f_onehot_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) ||
           (a == 4'b1011) || (a == 4'b0111);
  endfunction

  // {valid, value}; anything outside the table decodes as invalid
  function automatic logic [4:0] f_dec(input logic [6:0] s);
    case (s)
      7'h40:   f_dec = {1'b1, 4'h0};
      7'h79:   f_dec = {1'b1, 4'h1};
      7'h24:   f_dec = {1'b1, 4'h2};
      7'h30:   f_dec = {1'b1, 4'h3};
      7'h19:   f_dec = {1'b1, 4'h4};
      7'h12:   f_dec = {1'b1, 4'h5};
      7'h02:   f_dec = {1'b1, 4'h6};
      7'h78:   f_dec = {1'b1, 4'h7};
      7'h00:   f_dec = {1'b1, 4'h8};
      7'h10:   f_dec = {1'b1, 4'h9};
      7'h08:   f_dec = {1'b1, 4'hA};
      7'h03:   f_dec = {1'b1, 4'hB};
      7'h46:   f_dec = {1'b1, 4'hC};
      7'h21:   f_dec = {1'b1, 4'hD};
      7'h06:   f_dec = {1'b1, 4'hE};
      7'h0E:   f_dec = {1'b1, 4'hF};
      default: f_dec = 5'b0_0000;
    endcase
  endfunction

  assign w_in      = {an, sseg, dp};
  assign w_s_an    = r_smp[11:8];
  assign w_s_seg   = r_smp[7:1];
  assign w_s_dp    = r_smp[0];
  assign w_chg     = (w_in != r_smp);
  assign w_an_chg  = (an != w_s_an);
  assign w_oh_s    = f_onehot_low(w_s_an);
  assign w_oh_live = f_onehot_low(an);
  assign w_idle_s  = (w_s_an == 4'hF);
  assign w_dec     = f_dec(w_s_seg);
  assign w_ok      = w_dec[4];
  assign w_full    = (r_mask == 4'hF);
  assign w_pub     = w_full && !r_bad;

  always_comb begin
    w_idx = 2'd0;
    case (w_s_an)
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_cap  = 1'b0;
    w_aset = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_oh_s) begin
          w_next = S_SETTLE;
        end else if (!w_idle_s && !w_chg && r_cnt == S_LAST) begin
          w_aset = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!w_oh_s) begin
          w_next = S_IDLE;
        end else if (!w_chg && r_cnt >= S_LAST) begin
          w_cap  = 1'b1;
          w_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_an_chg) begin
          w_next = w_oh_live ? S_SETTLE : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // a capture in the completing cycle still lands in the new frame
  always_comb begin
    w_mask_nx = w_full ? 4'h0 : r_mask;
    w_bad_nx  = w_full ? 1'b0 : r_bad;
    if (w_cap) begin
      w_mask_nx[w_idx] = 1'b1;
      if (!w_ok) w_bad_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_smp   <= '1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_smp   <= w_in;
      if (w_chg) begin
        r_cnt <= '0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask <= '0;
      r_bad  <= 1'b0;
      r_sh   <= '0;
      r_dsh  <= '0;
    end else begin
      r_mask <= w_mask_nx;
      r_bad  <= w_bad_nx;
      if (w_cap) begin
        r_sh[w_idx]  <= w_ok ? w_dec[3:0] : 4'h0;
        r_dsh[w_idx] <= ~w_s_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dig <= '0;
      r_dpo <= '0;
      r_fv  <= 1'b0;
      r_to  <= '0;
    end else begin
      r_fv <= w_pub;
      if (w_pub) begin
        r_dig <= r_sh;
        r_dpo <= r_dsh;
        r_to  <= '0;
      end else if (r_to != TO_MAX) begin
        r_to <= r_to + TW'(1);
      end
    end
  end

  // a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_serr <= 1'b0;
      r_aerr <= 1'b0;
    end else begin
      if (w_cap && !w_ok) r_serr <= 1'b1;
      else if (clr_err)   r_serr <= 1'b0;
      if (w_aset)         r_aerr <= 1'b1;
      else if (clr_err)   r_aerr <= 1'b0;
    end
  end

  assign dig0        = r_dig[0];
  assign dig1        = r_dig[1];
  assign dig2        = r_dig[2];
  assign dig3        = r_dig[3];
  assign dp_out      = r_dpo;
  assign frame_valid = r_fv;
  assign seg_err     = r_serr;
  assign an_err      = r_aerr;
  assign stale       = (r_to == TO_MAX);

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: table of full scans plus
// hand-written sequences for settling, errors, timeout and reset.
module tb_sseg_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic       clr_err;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [3:0] dp_out;
  logic       frame_valid;
  logic       seg_err;
  logic       an_err;
  logic       stale;

  always #5 clk = ~clk;

  sseg_scan_decoder #(.SETTLE(16), .TIMEOUT(300)) dut (
    .clk(clk),
    .reset(reset),
    .an(an),
    .sseg(sseg),
    .dp(dp),
    .clr_err(clr_err),
    .dig0(dig0),
    .dig1(dig1),
    .dig2(dig2),
    .dig3(dig3),
    .dp_out(dp_out),
    .frame_valid(frame_valid),
    .seg_err(seg_err),
    .an_err(an_err),
    .stale(stale)
  );

  typedef struct {
    logic [27:0] segs;
    logic [3:0]  dpl;
    logic [15:0] dig;
    logic [3:0]  dpo;
    int          fv;
    logic        serr;
  } vec_t;

  vec_t vecs [6];
  int n_vec = 0;
  int n_bad = 0;

  int   fv_cnt = 0;
  int   serr_hi = 0;
  logic stale_prev = 1'b0;
  logic stale_pre_fv = 1'b0;
  logic stale_at_fv = 1'b1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt++;
      stale_pre_fv = stale_prev;
      stale_at_fv  = stale;
    end
    if (seg_err) serr_hi++;
    stale_prev = stale;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s,
                       input logic d, input int n);
    an   = a;
    sseg = s;
    dp   = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 7'h7F, 1'b1, n);
  endtask

  task automatic scan(input logic [27:0] segs, input logic [3:0] dpl,
                      input int lo, input int hi);
    logic [3:0] a;
    for (int i = lo; i < hi; i++) begin
      a = ~(4'b0001 << i);
      drive(a, segs[i*7 +: 7], dpl[i], 20);
    end
  endtask

  function automatic logic [15:0] digs();
    return {dig3, dig2, dig1, dig0};
  endfunction

  int base;
  int sbase;

  initial begin
    vecs[0] = '{{7'h19, 7'h30, 7'h24, 7'h79}, 4'b1011,
                16'h4321, 4'b0100, 1, 1'b0};
    vecs[1] = '{{7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111,
                16'h3210, 4'b0000, 1, 1'b0};
    vecs[2] = '{{7'h78, 7'h02, 7'h12, 7'h19}, 4'b1110,
                16'h7654, 4'b0001, 1, 1'b0};
    vecs[3] = '{{7'h03, 7'h08, 7'h10, 7'h00}, 4'b0000,
                16'hBA98, 4'b1111, 1, 1'b0};
    vecs[4] = '{{7'h0E, 7'h06, 7'h21, 7'h46}, 4'b0111,
                16'hFEDC, 4'b1000, 1, 1'b0};
    vecs[5] = '{{7'h7F, 7'h12, 7'h12, 7'h12}, 4'b1111,
                16'hFEDC, 4'b1000, 0, 1'b1};

    reset   = 1'b0;
    clr_err = 1'b0;
    an      = 4'hF;
    sseg    = 7'h7F;
    dp      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dig", 32'(digs()), 32'h0);
    chk("rst_dp", 32'(dp_out), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_serr", 32'(seg_err), 32'h0);
    chk("rst_aerr", 32'(an_err), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    reset = 1'b1;
    idle(5);

    for (int v = 0; v < 6; v++) begin
      base = fv_cnt;
      scan(vecs[v].segs, vecs[v].dpl, 0, 4);
      idle(5);
      chk($sformatf("v%0d_fv", v), 32'(fv_cnt - base), 32'(vecs[v].fv));
      chk($sformatf("v%0d_dig", v), 32'(digs()), 32'(vecs[v].dig));
      chk($sformatf("v%0d_dp", v), 32'(dp_out), 32'(vecs[v].dpo));
      chk($sformatf("v%0d_serr", v), 32'(seg_err), 32'(vecs[v].serr));
    end

    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("serr_clr", 32'(seg_err), 32'h0);

    // error raised while clear is held: flag must still be seen high
    base  = fv_cnt;
    sbase = serr_hi;
    clr_err = 1'b1;
    scan({7'h79, 7'h79, 7'h79, 7'h7F}, 4'hF, 0, 4);
    idle(5);
    clr_err = 1'b0;
    chk("clr_race_hi", 32'(serr_hi - sbase), 32'd1);
    chk("clr_race_end", 32'(seg_err), 32'h0);
    chk("clr_race_fv", 32'(fv_cnt - base), 32'd0);

    chk("aerr_pre", 32'(an_err), 32'h0);
    base = fv_cnt;
    scan({7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 0, 2);
    drive(4'b1100, 7'h40, 1'b1, 30);
    chk("aerr_set", 32'(an_err), 32'h1);
    scan({7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 2, 4);
    idle(5);
    chk("aerr_fv", 32'(fv_cnt - base), 32'd1);
    chk("aerr_dig", 32'(digs()), 32'h4321);
    chk("aerr_dp", 32'(dp_out), 32'h0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("aerr_clr", 32'(an_err), 32'h0);
    base = fv_cnt;
    scan({7'h00, 7'h00, 7'h00, 7'h00}, 4'hF, 0, 4);
    idle(5);
    chk("aerr_next_fv", 32'(fv_cnt - base), 32'd1);
    chk("aerr_next_dig", 32'(digs()), 32'h8888);

    // digit 1 toggles faster than it can settle, then holds a 5
    base = fv_cnt;
    drive(4'b1110, 7'h40, 1'b1, 20);
    for (int t = 0; t < 4; t++) begin
      drive(4'b1101, (t % 2 == 0) ? 7'h24 : 7'h30, 1'b1, 8);
    end
    drive(4'b1101, 7'h12, 1'b1, 20);
    drive(4'b1011, 7'h78, 1'b1, 20);
    drive(4'b0111, 7'h00, 1'b1, 20);
    idle(5);
    chk("tog_fv", 32'(fv_cnt - base), 32'd1);
    chk("tog_dig", 32'(digs()), 32'h8750);

    idle(250);
    chk("stale_lo", 32'(stale), 32'h0);
    idle(60);
    chk("stale_hi", 32'(stale), 32'h1);
    base = fv_cnt;
    scan({7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 0, 4);
    idle(5);
    chk("stale_fv", 32'(fv_cnt - base), 32'd1);
    chk("stale_pre_pub", 32'(stale_pre_fv), 32'h1);
    chk("stale_after_pub", 32'(stale_at_fv), 32'h0);

    scan({7'h00, 7'h00, 7'h00, 7'h00}, 4'hF, 0, 3);
    base  = fv_cnt;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_dig", 32'(digs()), 32'h0);
    chk("mid_rst_fv", 32'(frame_valid), 32'h0);
    chk("mid_rst_stale", 32'(stale), 32'h0);
    reset = 1'b1;
    idle(5);
    chk("rel_fv", 32'(fv_cnt - base), 32'd0);
    scan({7'h21, 7'h46, 7'h03, 7'h08}, 4'hF, 0, 4);
    idle(5);
    chk("post_rst_fv", 32'(fv_cnt - base), 32'd1);
    chk("post_rst_dig", 32'(digs()), 32'hDCBA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE, default 16: consecutive cycles of unchanged {an,sseg,dp} required before a digit is captured (legal range 2..255).
REQ-002 The block SHALL have parameter TIMEOUT, default 65536: cycles without a completed frame before stale asserts.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port an, input, 4 bits: active-low anode enables; bit i selects digit i.
REQ-006 The block SHALL have port sseg, input, 7 bits: active-low segments, order {g,f,e,d,c,b,a}.
REQ-007 The block SHALL have port dp, input, 1 bit: active-low decimal point.
REQ-008 The block SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-009 The block SHALL have ports dig0..dig3, output, 4 bits each: last published hex value of digit 0..3.
REQ-010 The block SHALL have port dp_out, output, 4 bits: last published decimal points, active-high, bit i = digit i.
REQ-011 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when a new frame is published.
REQ-012 The block SHALL have port seg_err, output, 1 bit: sticky; an undecodable segment pattern was captured.
REQ-013 The block SHALL have port an_err, output, 1 bit: sticky; more than one anode was low while otherwise stable.
REQ-014 The block SHALL have port stale, output, 1 bit: high while TIMEOUT has elapsed since the last publish.

Function
REQ-015 The block SHALL register {an,sseg,dp} once per cycle and compare against the prior registered value; any difference SHALL zero the stability counter.
REQ-016 The FSM SHALL have states IDLE, SETTLE, HOLD.
REQ-017 In IDLE, the FSM SHALL move to SETTLE when an is one-hot-low, and SHALL stay in IDLE when an is 4'hF.
REQ-018 In SETTLE, the FSM SHALL capture once the counter reaches SETTLE-1 with inputs unchanged, then move to HOLD.
REQ-019 In SETTLE, any input change SHALL restart counting; an becoming 4'hF SHALL return the FSM to IDLE.
REQ-020 In HOLD, any change of an SHALL move the FSM to SETTLE (one-hot) or to IDLE (all high); sseg/dp changes alone SHALL be ignored.
REQ-021 Capture SHALL decode sseg into a shadow register for the selected digit and set that digit's bit in a 4-bit capture mask.
REQ-022 The decode table in hex SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-023 Any other pattern SHALL store 4'h0, set seg_err, and mark the current frame bad.
REQ-024 When the mask becomes 4'hF, the next cycle SHALL clear the mask and, if the frame is not bad, copy the shadows to dig0..dig3/dp_out and pulse frame_valid for exactly 1 cycle.
REQ-025 A bad frame SHALL be discarded with no publish and no frame_valid, and the bad flag SHALL clear.
REQ-026 Re-capturing an already-set mask digit SHALL overwrite its shadow value without completing a frame.
REQ-027 If an has two or more bits low for SETTLE stable cycles, the block SHALL set an_err, perform no capture, leave the mask unchanged, and put the FSM in IDLE.
REQ-028 The timeout counter SHALL saturate at TIMEOUT; stale SHALL equal (counter==TIMEOUT), and the counter SHALL zero on each publish.
REQ-029 When clr_err and a new error occur in the same cycle, the error SHALL win and the flag SHALL stay 1.

Reset
REQ-030 While reset=0, the FSM SHALL be in IDLE and counters, mask, shadows, and bad flag SHALL be 0.
REQ-031 While reset=0, dig0..dig3=0, dp_out=0, frame_valid=0, seg_err=0, an_err=0, stale=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; no frame_valid SHALL follow reset release.

Verification
REQ-033 Scan digits 0..3 showing 1,2,3,4 (79,24,30,19), dp low on digit 2, 20 cycles each -> one frame_valid; dig0..3=1,2,3,4; dp_out=4'b0100.
REQ-034 Digit 1 sseg toggles every 8 cycles (SETTLE=16), then holds 7'h12 for 20 cycles -> exactly one capture, dig1=5 after the frame.
REQ-035 Digit 3 shows 7'h7F in an otherwise valid scan -> seg_err=1, no frame_valid, outputs keep prior values; clr_err for 1 cycle -> seg_err=0.
REQ-036 an=4'b1100 stable for 30 cycles -> an_err=1, mask unchanged; a following full valid scan -> frame_valid pulses.
REQ-037 No scan for TIMEOUT cycles -> stale=1; one valid frame -> stale=0 on the cycle after the publish.
REQ-038 reset driven low after 3 digits are captured, then a full scan -> exactly one frame_valid, containing only the post-reset values.
